multicycle_ctrl: RTL and testbench

Multicycle sequencer for the MIPS core. Steps one shared datapath (register file, ALU, unified memory port, PC/IR registers) through fetch, decode, execute, memory and write-back phases, one instruction at a time. Memory accesses use a req/ready handshake. The block also counts retired instructions. It replaces per-instruction single-cycle control when the core runs against a single wait-stated memory.

---
 rtl/multicycle_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_decode.sv | 73 +++++++
 rtl/multicycle_ctrl.sv | 121 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS sequencer: states, mux selects,
// ALU op codes, instruction classes and opcode/funct values.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } st_e;

    typedef enum logic [2:0] {
        CL_RTYPE, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL
    } class_e;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC4 = 2'd2;

    localparam logic [1:0] ALU_SRC_REG        = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the shared
// datapath / memory port (slave).
interface multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_src;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
    logic        halt;
    logic [2:0]  state;
    logic [31:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, reg_dst, wb_src, alu_src, alu_op, halt, state, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, reg_dst, wb_src, alu_src, alu_op, halt, state, retired
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU controls,
// destination register select and an illegal-instruction flag.
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output class_e     o_class,
    output logic [2:0] o_alu_op,
    output logic [1:0] o_alu_src,
    output logic [1:0] o_reg_dst,
    output logic       o_illegal
);
    always_comb begin
        o_class   = CL_RTYPE;
        o_alu_op  = OP_ADD;
        o_alu_src = ALU_SRC_REG;
        o_reg_dst = REG_DST_RT;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_RTYPE: begin
                o_reg_dst = REG_DST_RD;
                case (i_funct)
                    FN_ADD:  o_alu_op = OP_ADD;
                    FN_SUB:  o_alu_op = OP_SUB;
                    FN_AND:  o_alu_op = OP_AND;
                    FN_OR:   o_alu_op = OP_OR;
                    FN_NOR:  o_alu_op = OP_NOR;
                    FN_SLT:  o_alu_op = OP_SLT;
                    FN_SLL:  o_alu_op = OP_SLL;
                    FN_SRL:  o_alu_op = OP_SRL;
                    default: o_illegal = 1'b1;
                endcase
            end
            OPC_ADDI: begin
                o_class   = CL_IALU;
                o_alu_src = ALU_SRC_SEXT_IMM16;
            end
            OPC_ANDI: begin
                o_class   = CL_IALU;
                o_alu_src = ALU_SRC_ZEXT_IMM16;
                o_alu_op  = OP_AND;
            end
            OPC_ORI: begin
                o_class   = CL_IALU;
                o_alu_src = ALU_SRC_ZEXT_IMM16;
                o_alu_op  = OP_OR;
            end
            OPC_LW: begin
                o_class   = CL_LW;
                o_alu_src = ALU_SRC_SEXT_IMM16;
            end
            OPC_SW: begin
                o_class   = CL_SW;
                o_alu_src = ALU_SRC_SEXT_IMM16;
            end
            OPC_BEQ: begin
                o_class  = CL_BEQ;
                o_alu_op = OP_SUB;
            end
            OPC_BNE: begin
                o_class  = CL_BNE;
                o_alu_op = OP_SUB;
            end
            OPC_J:   o_class = CL_J;
            OPC_JAL: begin
                o_class   = CL_JAL;
                o_reg_dst = REG_DST_RA;
            end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: steps the shared datapath through fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    st_e         r_state;
    st_e         w_state_next;
    logic [31:0] r_retired;
    logic        w_retire;
    class_e      w_class;
    logic [2:0]  w_alu_op;
    logic [1:0]  w_alu_src;
    logic [1:0]  w_reg_dst;
    logic        w_illegal;

    mc_decode u_decode (
        .i_opcode  (bus.opcode),
        .i_funct   (bus.funct),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_alu_src (w_alu_src),
        .o_reg_dst (w_reg_dst),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_BOOT;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) r_retired <= r_retired + 32'd1;
        end
    end

    // Strobes depend on state plus live mem_ready/zero, so a stalled request
    // holds mem_req high and reset drops it without waiting for an edge.
    always_comb begin
        w_state_next     = r_state;
        w_retire         = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = PC_SRC_PLUS4;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = REG_DST_RT;
        bus.wb_src       = WB_SRC_ALU;
        bus.alu_src      = ALU_SRC_REG;
        bus.alu_op       = OP_ADD;
        bus.halt         = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = ST_FETCH;
            ST_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    w_state_next = ST_TRAP;
                end else if (w_class == CL_J || w_class == CL_JAL) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_SRC_JUMP;
                    if (w_class == CL_JAL) begin
                        bus.reg_write = 1'b1;
                        bus.reg_dst   = w_reg_dst;
                        bus.wb_src    = WB_SRC_PC4;
                    end
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.alu_src = w_alu_src;
                bus.alu_op  = w_alu_op;
                if (w_class == CL_BEQ || w_class == CL_BNE) begin
                    bus.pc_src   = PC_SRC_BRANCH;
                    bus.pc_write = (w_class == CL_BEQ) ? bus.zero : ~bus.zero;
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end else if (w_class == CL_LW || w_class == CL_SW) begin
                    w_state_next = ST_MEM;
                end else begin
                    w_state_next = ST_WB;
                end
            end
            ST_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (w_class == CL_SW);
                if (bus.mem_ready) begin
                    w_retire     = (w_class == CL_SW);
                    w_state_next = (w_class == CL_SW) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = w_reg_dst;
                bus.wb_src    = (w_class == CL_LW) ? WB_SRC_MEM : WB_SRC_ALU;
                w_retire      = 1'b1;
                w_state_next  = ST_FETCH;
            end
            ST_TRAP: bus.halt = 1'b1;
            default: w_state_next = ST_BOOT;
        endcase
    end

    assign bus.state   = r_state;
    assign bus.retired = r_retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and compares every output at each cycle.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic [1:0] alu_src;
        logic [2:0] alu_op;
        logic       halt;
    } snap_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic snap_t snap();
        snap_t s;
        s.st = bus.state; s.mem_req = bus.mem_req; s.mem_we = bus.mem_we;
        s.mem_addr_sel = bus.mem_addr_sel; s.ir_write = bus.ir_write;
        s.pc_write = bus.pc_write; s.pc_src = bus.pc_src; s.reg_write = bus.reg_write;
        s.reg_dst = bus.reg_dst; s.wb_src = bus.wb_src; s.alu_src = bus.alu_src;
        s.alu_op = bus.alu_op; s.halt = bus.halt;
        return s;
    endfunction

    function automatic snap_t fetch_acc();
        snap_t e = '0;
        e.st = ST_FETCH; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        e.pc_src = PC_SRC_PLUS4;
        return e;
    endfunction

    function automatic snap_t only_state(input st_e st);
        snap_t e = '0;
        e.st = st;
        return e;
    endfunction

    task automatic set_ir(input logic [31:0] ir);
        bus.opcode = ir[31:26];
        bus.funct  = ir[5:0];
    endtask

    task automatic test_reset();
        snap_t e;
        bus.mem_ready = 1'b0; bus.zero = 1'b0; set_ir(32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        e = only_state(ST_BOOT);
        n_checks++; if (snap() !== e) $display("FAIL reset_hold: got %h want %h", snap(), e); else n_pass++;
        reset = 1'b0; #1;
        n_checks++; if (snap() !== e) $display("FAIL reset_boot: got %h want %h", snap(), e); else n_pass++;
        n_checks++; if (bus.retired !== 32'd0) $display("FAIL reset_retired: got %h want 0", bus.retired); else n_pass++;
        @(negedge clk);
        e.st = ST_FETCH; e.mem_req = 1'b1;
        n_checks++; if (snap() !== e) $display("FAIL reset_fetch: got %h want %h", snap(), e); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_addi();
        snap_t e;
        set_ir(32'h2010FEFE); bus.mem_ready = 1'b1; #1;
        e = fetch_acc();
        n_checks++; if (snap() !== e) $display("FAIL addi_fetch: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_DECODE);
        n_checks++; if (snap() !== e) $display("FAIL addi_decode: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_EXEC); e.alu_op = OP_ADD; e.alu_src = ALU_SRC_SEXT_IMM16;
        n_checks++; if (snap() !== e) $display("FAIL addi_exec: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_WB); e.reg_write = 1'b1; e.reg_dst = REG_DST_RT; e.wb_src = WB_SRC_ALU;
        n_checks++; if (snap() !== e) $display("FAIL addi_wb: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.state !== ST_FETCH) $display("FAIL addi_back: got %0d want %0d", bus.state, ST_FETCH); else n_pass++;
        n_checks++; if (bus.retired !== 32'd1) $display("FAIL addi_retired: got %h want 1", bus.retired); else n_pass++;
        $display("test_addi done retired=%0d", bus.retired);
    endtask

    task automatic test_lw_wait();
        snap_t e;
        set_ir(32'h8D090004); bus.mem_ready = 1'b1; #1;
        e = fetch_acc();
        n_checks++; if (snap() !== e) $display("FAIL lw_fetch: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_DECODE);
        n_checks++; if (snap() !== e) $display("FAIL lw_decode: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_EXEC); e.alu_op = OP_ADD; e.alu_src = ALU_SRC_SEXT_IMM16;
        n_checks++; if (snap() !== e) $display("FAIL lw_exec: got %h want %h", snap(), e); else n_pass++;
        bus.mem_ready = 1'b0;
        e = only_state(ST_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (snap() !== e) $display("FAIL lw_mem_wait%0d: got %h want %h", i, snap(), e); else n_pass++;
        end
        bus.mem_ready = 1'b1; #1;
        n_checks++; if (snap() !== e) $display("FAIL lw_mem_ready: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_WB); e.reg_write = 1'b1; e.reg_dst = REG_DST_RT; e.wb_src = WB_SRC_MEM;
        n_checks++; if (snap() !== e) $display("FAIL lw_wb: got %h want %h", snap(), e); else n_pass++;
        n_checks++; if (bus.retired !== 32'd1) $display("FAIL lw_early_retire: got %h want 1", bus.retired); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.state !== ST_FETCH || bus.retired !== 32'd2) $display("FAIL lw_done: state %0d retired %h want %0d 2", bus.state, bus.retired, ST_FETCH); else n_pass++;
        $display("test_lw_wait done retired=%0d", bus.retired);
    endtask

    task automatic test_branch();
        snap_t e;
        logic [31:0] irs [2];
        irs[0] = 32'h1108FFFF; irs[1] = 32'h1508FFFF;
        bus.zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_ir(irs[k]); bus.mem_ready = 1'b1; #1;
            e = fetch_acc();
            n_checks++; if (snap() !== e) $display("FAIL br%0d_fetch: got %h want %h", k, snap(), e); else n_pass++;
            @(negedge clk); e = only_state(ST_DECODE);
            n_checks++; if (snap() !== e) $display("FAIL br%0d_decode: got %h want %h", k, snap(), e); else n_pass++;
            @(negedge clk); e = only_state(ST_EXEC); e.alu_op = OP_SUB; e.alu_src = ALU_SRC_REG;
            e.pc_src = PC_SRC_BRANCH; e.pc_write = (k == 0);
            n_checks++; if (snap() !== e) $display("FAIL br%0d_exec_z1: got %h want %h", k, snap(), e); else n_pass++;
            bus.zero = 1'b0; #1; e.pc_write = (k == 1);
            n_checks++; if (snap() !== e) $display("FAIL br%0d_exec_z0: got %h want %h", k, snap(), e); else n_pass++;
            bus.zero = 1'b1;
            @(negedge clk);
            n_checks++; if (bus.state !== ST_FETCH || bus.retired !== 32'd3 + k) $display("FAIL br%0d_done: state %0d retired %h want %0d %0d", k, bus.state, bus.retired, ST_FETCH, 3 + k); else n_pass++;
        end
        bus.zero = 1'b0;
        $display("test_branch done retired=%0d", bus.retired);
    endtask

    task automatic test_sw();
        snap_t e;
        set_ir(32'hAD090008); bus.mem_ready = 1'b1; #1;
        e = fetch_acc();
        n_checks++; if (snap() !== e) $display("FAIL sw_fetch: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk);
        @(negedge clk); e = only_state(ST_EXEC); e.alu_op = OP_ADD; e.alu_src = ALU_SRC_SEXT_IMM16;
        n_checks++; if (snap() !== e) $display("FAIL sw_exec: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = 1'b1;
        n_checks++; if (snap() !== e) $display("FAIL sw_mem: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.state !== ST_FETCH || bus.retired !== 32'd5) $display("FAIL sw_done: state %0d retired %h want %0d 5", bus.state, bus.retired, ST_FETCH); else n_pass++;
        $display("test_sw done retired=%0d", bus.retired);
    endtask

    task automatic test_rtype_jal();
        snap_t e;
        set_ir(32'h01095022); bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); e = only_state(ST_EXEC); e.alu_op = OP_SUB; e.alu_src = ALU_SRC_REG;
        n_checks++; if (snap() !== e) $display("FAIL sub_exec: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_WB); e.reg_write = 1'b1; e.reg_dst = REG_DST_RD; e.wb_src = WB_SRC_ALU;
        n_checks++; if (snap() !== e) $display("FAIL sub_wb: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.retired !== 32'd6) $display("FAIL sub_retired: got %h want 6", bus.retired); else n_pass++;
        set_ir(32'h0C000010);
        @(negedge clk); e = only_state(ST_DECODE); e.pc_write = 1'b1; e.pc_src = PC_SRC_JUMP;
        e.reg_write = 1'b1; e.reg_dst = REG_DST_RA; e.wb_src = WB_SRC_PC4;
        n_checks++; if (snap() !== e) $display("FAIL jal_decode: got %h want %h", snap(), e); else n_pass++;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.state !== ST_FETCH || bus.retired !== 32'd7) $display("FAIL jal_done: state %0d retired %h want %0d 7", bus.state, bus.retired, ST_FETCH); else n_pass++;
        $display("test_rtype_jal done retired=%0d", bus.retired);
    endtask

    task automatic test_trap();
        snap_t e;
        set_ir(32'hFC000000); bus.mem_ready = 1'b1;
        @(negedge clk); e = only_state(ST_DECODE);
        n_checks++; if (snap() !== e) $display("FAIL trap_decode: got %h want %h", snap(), e); else n_pass++;
        e = only_state(ST_TRAP); e.halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (snap() !== e || bus.retired !== 32'd7) $display("FAIL trap_hold%0d: got %h/%h want %h/7", i, snap(), bus.retired, e); else n_pass++;
        end
        bus.mem_ready = 1'b0;
        #3 reset = 1'b1; #1;
        e = only_state(ST_BOOT);
        n_checks++; if (snap() !== e || bus.retired !== 32'd0) $display("FAIL trap_async_reset: got %h/%h want %h/0", snap(), bus.retired, e); else n_pass++;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); e = only_state(ST_FETCH); e.mem_req = 1'b1;
        n_checks++; if (snap() !== e) $display("FAIL trap_restart: got %h want %h", snap(), e); else n_pass++;
        $display("test_trap done");
    endtask

    task automatic test_wrap();
        snap_t e;
        force dut.r_retired = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_retired;
        set_ir(32'h08000000); bus.mem_ready = 1'b1; #1;
        e = fetch_acc();
        n_checks++; if (snap() !== e) $display("FAIL j_fetch: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk); e = only_state(ST_DECODE); e.pc_write = 1'b1; e.pc_src = PC_SRC_JUMP;
        n_checks++; if (snap() !== e) $display("FAIL j_decode: got %h want %h", snap(), e); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.retired !== 32'd0) $display("FAIL wrap_zero: got %h want 0", bus.retired); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.retired !== 32'd1) $display("FAIL wrap_next: got %h want 1", bus.retired); else n_pass++;
        bus.mem_ready = 1'b0;
        $display("test_wrap done retired=%0d", bus.retired);
    endtask

    task automatic test_reset_mid_fetch();
        snap_t e;
        #1; e = only_state(ST_FETCH); e.mem_req = 1'b1;
        n_checks++; if (snap() !== e) $display("FAIL midreset_pre: got %h want %h", snap(), e); else n_pass++;
        #3 reset = 1'b1; #1;
        e = only_state(ST_BOOT);
        n_checks++; if (snap() !== e || bus.retired !== 32'd0) $display("FAIL midreset_drop: got %h/%h want %h/0", snap(), bus.retired, e); else n_pass++;
        bus.mem_ready = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        n_checks++; if (snap() !== e) $display("FAIL midreset_boot: got %h want %h", snap(), e); else n_pass++;
        bus.mem_ready = 1'b0;
        @(negedge clk); e = only_state(ST_FETCH); e.mem_req = 1'b1;
        n_checks++; if (snap() !== e) $display("FAIL midreset_fetch: got %h want %h", snap(), e); else n_pass++;
        $display("test_reset_mid_fetch done");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_branch();
        test_sw();
        test_rtype_jal();
        test_trap();
        test_wrap();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
